// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer:
// states, opcodes, class one-hots and fault codes.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALUI0 = 4'b0000;
  localparam logic [3:0] OP_ALUI1 = 4'b0001;
  localparam logic [3:0] OP_ALUR0 = 4'b0010;
  localparam logic [3:0] OP_ALUR1 = 4'b0011;
  localparam logic [3:0] OP_LDST0 = 4'b0100;
  localparam logic [3:0] OP_LDST1 = 4'b0101;
  localparam logic [3:0] OP_BRN0  = 4'b0110;
  localparam logic [3:0] OP_BRN1  = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] CLS_NONE = 4'b0000;
  localparam logic [3:0] CLS_ALUI = 4'b0001;
  localparam logic [3:0] CLS_ALUR = 4'b0010;
  localparam logic [3:0] CLS_LDST = 4'b0100;
  localparam logic [3:0] CLS_BRN  = 4'b1000;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Opcode classifier: maps the top nibble of the
// instruction to a class one-hot, halt or illegal.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] classOh,
  output logic       isHalt,
  output logic       isIllegal
);

  always_comb begin
    classOh   = CLS_NONE;
    isHalt    = 1'b0;
    isIllegal = 1'b0;
    unique case (opcode)
      OP_ALUI0, OP_ALUI1: classOh = CLS_ALUI;
      OP_ALUR0, OP_ALUR1: classOh = CLS_ALUR;
      OP_LDST0, OP_LDST1: classOh = CLS_LDST;
      OP_BRN0,  OP_BRN1:  classOh = CLS_BRN;
      OP_HALT:            isHalt  = 1'b1;
      default:            isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Top-level instruction sequencer: fetch/latch/decode
// and dispatch to sub-FSMs with a done timeout.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instrIn,
  input  logic [3:0]  subDone,
  output logic        imemRd,
  output logic        irLatch,
  output logic [15:0] instrOut,
  output logic [3:0]  fsmStart,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  faultCode,
  output logic [15:0] retired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;
  logic [15:0] r_retired;
  logic [TW-1:0] r_tmo;
  logic [1:0]  r_fault;

  logic [3:0]  w_cls;
  logic        w_halt;
  logic        w_ill;
  logic        w_done;
  logic        w_tmo_hit;
  logic        w_retire;

  instr_decode u_dec (
    .opcode   (r_instr[15:12]),
    .classOh  (w_cls),
    .isHalt   (w_halt),
    .isIllegal(w_ill)
  );

  // only the dispatched class may end EXEC
  assign w_done    = |(subDone & w_cls);
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_next   = r_state;
    imemRd   = 1'b0;
    irLatch  = 1'b0;
    fsmStart = CLS_NONE;
    busy     = 1'b1;
    halted   = 1'b0;
    w_retire = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        imemRd = 1'b1;
        w_next = ST_LATCH;
      end
      ST_LATCH: begin
        irLatch = 1'b1;
        w_next  = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_halt) begin
          w_next   = ST_HALT;
          w_retire = 1'b1;
        end else if (w_ill) begin
          w_next = ST_FAULT;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        fsmStart = w_cls;
        if (w_done) begin
          w_retire = 1'b1;
          w_next   = run ? ST_FETCH : ST_IDLE;
        end else if (w_tmo_hit) begin
          w_next = ST_FAULT;
        end
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_retired <= '0;
      r_tmo     <= '0;
      r_fault   <= FLT_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_LATCH) r_instr <= instrIn;
      if (r_state == ST_DECODE) r_tmo <= '0;
      else if (r_state == ST_EXEC) r_tmo <= r_tmo + 1'b1;
      if (w_retire) r_retired <= r_retired + 16'd1;
      if (r_state == ST_DECODE && !w_halt && w_ill)
        r_fault <= FLT_ILLEGAL;
      if (r_state == ST_EXEC && !w_done && w_tmo_hit)
        r_fault <= FLT_TIMEOUT;
    end
  end

  assign instrOut  = r_instr;
  assign retired   = r_retired;
  assign faultCode = r_fault;

endmodule
